// File: rtl/demux_pkg.sv
// demux_pkg: mode constants and select-width helper shared by the demux lane array
package demux_pkg;
  localparam int MODE_EXT = 0;
  localparam int MODE_RR  = 1;
  function automatic int sel_w(input int fanout);
    return (fanout <= 2) ? 1 : $clog2(fanout);
  endfunction
endpackage

// File: rtl/demux_lane.sv
// demux_lane: one 1:FANOUT lane with one-entry output registers, round-robin pointer and sticky select error
module demux_lane
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FANOUT = 2,
  parameter int MODE   = MODE_EXT,
  parameter int SEL_W  = sel_w(FANOUT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic [FANOUT*DATA_W-1:0] out_data,
  output logic [FANOUT-1:0]        out_valid,
  input  logic [FANOUT-1:0]        out_ready,
  output logic                     sel_err
);
  logic [SEL_W-1:0] rr, target;
  logic sel_bad, accept;
  // the out-of-range check gates the indexed lookup, so a bad select never reaches out_valid[target]
  always_comb begin
    target   = (MODE == MODE_RR) ? rr : sel;
    sel_bad  = (MODE == MODE_EXT) && ({1'b0, sel} >= (SEL_W+1)'(FANOUT));
    in_ready = !reset && !sel_bad && (!out_valid[target] || out_ready[target]);
    accept   = in_valid && in_ready;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= '0;
      out_data  <= '0;
      rr        <= '0;
      sel_err   <= 1'b0;
    end else begin
      for (int j = 0; j < FANOUT; j++)
        if (accept && target == SEL_W'(j)) begin
          out_valid[j]                  <= 1'b1;
          out_data[j*DATA_W +: DATA_W]  <= in_data;
        end else if (out_ready[j]) out_valid[j] <= 1'b0;
      if (in_valid && sel_bad) sel_err <= 1'b1;
      if (MODE == MODE_RR && accept) rr <= (rr == SEL_W'(FANOUT - 1)) ? '0 : rr + 1'b1;
    end
  end
endmodule

// File: rtl/demux_lane_array.sv
// demux_lane_array: NUM_IN independent 1:FANOUT demux lanes with registered outputs
module demux_lane_array
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_IN = 2,
  parameter int FANOUT = 2,
  parameter int MODE   = MODE_EXT,
  localparam int SEL_W = sel_w(FANOUT)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_IN*DATA_W-1:0]        in_data,
  input  logic [NUM_IN-1:0]               in_valid,
  output logic [NUM_IN-1:0]               in_ready,
  input  logic [NUM_IN*SEL_W-1:0]         sel,
  output logic [NUM_IN*FANOUT*DATA_W-1:0] out_data,
  output logic [NUM_IN*FANOUT-1:0]        out_valid,
  input  logic [NUM_IN*FANOUT-1:0]        out_ready,
  output logic [NUM_IN-1:0]               sel_err
);
  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    demux_lane #(.DATA_W(DATA_W), .FANOUT(FANOUT), .MODE(MODE), .SEL_W(SEL_W)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data[i*DATA_W +: DATA_W]),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .sel       (sel[i*SEL_W +: SEL_W]),
      .out_data  (out_data[i*FANOUT*DATA_W +: FANOUT*DATA_W]),
      .out_valid (out_valid[i*FANOUT +: FANOUT]),
      .out_ready (out_ready[i*FANOUT +: FANOUT]),
      .sel_err   (sel_err[i])
    );
  end
endmodule

// File: tb/tb_demux_lane_array.sv
// tb_demux_lane_array: directed vectors and randomized model check for demux_lane_array
module tb_demux_lane_array;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;

  logic [15:0] a_in_data = '0;
  logic [1:0]  a_in_valid = '0, a_in_ready, a_sel = '0, a_sel_err;
  logic [31:0] a_out_data;
  logic [3:0]  a_out_valid, a_out_ready = '0;
  demux_lane_array #(.DATA_W(8), .NUM_IN(2), .FANOUT(2), .MODE(0)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sel(a_sel), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .sel_err(a_sel_err));

  logic [7:0]  b_in_data = '0;
  logic [0:0]  b_in_valid = '0, b_in_ready, b_sel_err;
  logic [1:0]  b_sel = '0;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_valid, b_out_ready = '0;
  demux_lane_array #(.DATA_W(8), .NUM_IN(1), .FANOUT(4), .MODE(1)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sel(b_sel), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .sel_err(b_sel_err));

  logic [7:0]  c_in_data = '0;
  logic [0:0]  c_in_valid = '0, c_in_ready, c_sel_err;
  logic [1:0]  c_sel = '0;
  logic [23:0] c_out_data;
  logic [2:0]  c_out_valid, c_out_ready = '0;
  demux_lane_array #(.DATA_W(8), .NUM_IN(1), .FANOUT(3), .MODE(0)) dut_c (
    .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sel(c_sel), .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .sel_err(c_sel_err));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  typedef struct {
    logic v; logic s; logic [7:0] d; logic [1:0] ordy;
    logic exp_rdy; logic [1:0] exp_ov; logic [15:0] exp_od;
  } vec_t;
  vec_t tbl[6];

  logic [3:0] m_ov;
  logic [7:0] m_od[4];
  logic [1:0] acc;
  logic [31:0] m_pack;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 8'hA5, 2'b11, 1'b1, 2'b10, 16'hA500};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 2'b11, 1'b1, 2'b00, 16'hA500};
    tbl[2] = '{1'b1, 1'b0, 8'h11, 2'b10, 1'b1, 2'b01, 16'hA511};
    tbl[3] = '{1'b1, 1'b0, 8'h22, 2'b10, 1'b0, 2'b01, 16'hA511};
    tbl[4] = '{1'b1, 1'b0, 8'h22, 2'b11, 1'b1, 2'b01, 16'hA522};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 2'b00, 16'hA522};
    a_out_ready = 4'hF; b_out_ready = 4'hF; c_out_ready = 3'h7;
    #1;
    chk("rst_a_ov", a_out_valid, 0); chk("rst_a_od", a_out_data, 0);
    chk("rst_a_rdy", a_in_ready, 0); chk("rst_a_err", a_sel_err, 0);
    chk("rst_b_ov", b_out_valid, 0); chk("rst_b_rdy", b_in_ready, 0);
    chk("rst_c_ov", c_out_valid, 0); chk("rst_c_err", c_sel_err, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      a_in_valid = {1'b0, tbl[r].v}; a_sel = {1'b0, tbl[r].s};
      a_in_data = {8'h00, tbl[r].d}; a_out_ready = {2'b00, tbl[r].ordy};
      #1 chk($sformatf("tbl%0d_rdy", r), a_in_ready[0], tbl[r].exp_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ov", r), a_out_valid[1:0], tbl[r].exp_ov);
      chk($sformatf("tbl%0d_od", r), a_out_data[15:0], tbl[r].exp_od);
    end
    // lane1 stuck on output 2 while lane0 streams at full rate
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      a_out_ready = 4'b0011;
      a_in_valid = 2'b11;
      a_sel = {1'b0, 1'(n % 2)};
      a_in_data = {8'(8'h77 + n), 8'(8'h30 + n)};
      #1;
      chk($sformatf("iso%0d_rdy0", n), a_in_ready[0], 1);
      chk($sformatf("iso%0d_rdy1", n), a_in_ready[1], (n == 0) ? 1 : 0);
      @(posedge clk);
      #1;
      chk($sformatf("iso%0d_ov0", n), a_out_valid[1:0], 2'b01 << (n % 2));
      chk($sformatf("iso%0d_od0", n), a_out_data[(n % 2)*8 +: 8], 8'h30 + n);
      chk($sformatf("iso%0d_l1", n), {a_out_valid[3:2], a_out_data[23:16]}, {2'b01, 8'h77});
    end
    @(negedge clk);
    a_in_valid = 2'b00;
    // out-of-range select on a 3-way lane
    @(negedge clk);
    c_in_valid = 1'b1; c_sel = 2'd3; c_in_data = 8'h3C; c_out_ready = 3'h7;
    #1 chk("err_rdy", c_in_ready, 0);
    @(posedge clk);
    #1;
    chk("err_set", c_sel_err, 1); chk("err_ov", c_out_valid, 0);
    @(negedge clk);
    c_sel = 2'd0;
    #1 chk("err_rdy_back", c_in_ready, 1);
    @(posedge clk);
    #1;
    chk("err_sticky", c_sel_err, 1); chk("err_ov0", c_out_valid, 3'b001);
    chk("err_od0", c_out_data[7:0], 8'h3C);
    @(negedge clk);
    c_sel = 2'd2; c_in_data = 8'h3D;
    @(posedge clk);
    #1;
    chk("err_ov2", c_out_valid, 3'b100); chk("err_od2", c_out_data[23:16], 8'h3D);
    @(negedge clk);
    c_in_valid = 1'b0;
    // round-robin streaming
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_data = 8'(8'h10 + n); b_out_ready = 4'hF;
      #1 chk($sformatf("rr%0d_rdy", n), b_in_ready, 1);
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_ov", n), b_out_valid, 4'b0001 << (n % 4));
      chk($sformatf("rr%0d_od", n), b_out_data[(n % 4)*8 +: 8], 8'h10 + n);
    end
    @(negedge clk);
    b_out_ready = 4'h0; b_in_data = 8'h20;
    @(posedge clk);
    @(negedge clk);
    b_in_data = 8'h21;
    @(posedge clk);
    #1;
    chk("hold_ov", b_out_valid, 4'b0111);
    chk("hold_od", b_out_data[23:0], 24'h212014);
    @(negedge clk);
    b_in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_b_ov", b_out_valid, 0); chk("arst_b_od", b_out_data, 0);
    chk("arst_b_rdy", b_in_ready, 0); chk("arst_a_ov", a_out_valid, 0);
    chk("arst_c_err", c_sel_err, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 8'h55; b_out_ready = 4'hF;
    #1 chk("post_rdy", b_in_ready, 1);
    @(posedge clk);
    #1;
    chk("post_ov", b_out_valid, 4'b0001); chk("post_od", b_out_data[7:0], 8'h55);
    @(negedge clk);
    b_in_valid = 1'b0;
    // randomized traffic on the two-lane array against a register-array model
    m_ov = '0;
    for (int k = 0; k < 4; k++) m_od[k] = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      a_in_valid = 2'($urandom); a_sel = 2'($urandom);
      a_in_data = 16'($urandom); a_out_ready = 4'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        int t;
        logic er;
        t = i*2 + int'(a_sel[i]);
        er = !m_ov[t] || a_out_ready[t];
        chk($sformatf("rnd%0d_rdy%0d", c, i), a_in_ready[i], er);
        acc[i] = a_in_valid[i] && er;
      end
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
        if (acc[k/2] && int'(a_sel[k/2]) == k % 2) begin
          m_ov[k] = 1'b1;
          m_od[k] = a_in_data[(k/2)*8 +: 8];
        end else if (a_out_ready[k]) m_ov[k] = 1'b0;
      end
      m_pack = {m_od[3], m_od[2], m_od[1], m_od[0]};
      #1;
      chk($sformatf("rnd%0d_ov", c), a_out_valid, m_ov);
      chk($sformatf("rnd%0d_od", c), a_out_data, m_pack);
    end
    chk("rnd_err", a_sel_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
